fetch_unit: RTL and testbench

// - Instruction fetch stage directly upstream of decode: owns the PC, issues sequential

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_buffer.sv | 67 ++++++
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int          BUF_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-side and decode-side signals of the fetch stage, bundled for port lists.
// Decode handshake: a word transfers on a cycle where valid_out && ready_out; once
// valid_out is high, instr/pc_out stay stable until that transfer happens.
interface fetch_unit_if;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        ready_out;

  modport master (
    input  mispredict, redirect_pc, imem_rdata, ready_out,
    output imem_req, imem_addr, instr, pc_out, valid_out
  );

  modport slave (
    output mispredict, redirect_pc, imem_rdata, ready_out,
    input  imem_req, imem_addr, instr, pc_out, valid_out
  );
endinterface

// File: rtl/fetch_unit_buffer.sv
// Small FIFO of fetched {pc, instr} pairs with a synchronous flush.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = BUF_DEPTH_DEFAULT,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_data     wdata,
  input  logic          pop,
  output fetch_data     head,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_data     mem_q [DEPTH];
  fetch_data     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage has no reset: entries are only observed after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one read per cycle under a credit limit and
// hands buffered {instr, pc} to decode; mispredict flushes and redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;

  logic          push, pop, issue, valid, buf_empty;
  logic [CW-1:0] buf_count;
  logic [CW:0]   credit_used;
  fetch_data     head;
  fetch_data     wdata;

  // A word already requested owns a slot, so count + inflight never exceeds depth.
  assign valid       = reset && !bus.mispredict && !buf_empty;
  assign pop         = valid && bus.ready_out;
  assign credit_used = {1'b0, buf_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue       = reset && !bus.mispredict && (credit_used < (CW+1)'(BUF_DEPTH));
  assign push        = inflight_q && reset && !bus.mispredict;
  assign wdata       = '{pc: req_pc_q, instr: bus.imem_rdata};

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (bus.mispredict) begin
      pc_d = align_pc(bus.redirect_pc);
    end else if (issue) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (bus.mispredict),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = reset ? pc_q : 32'h0;
  assign bus.valid_out = valid;
  assign bus.instr     = reset ? head.instr : 32'h0;
  assign bus.pc_out    = reset ? head.pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirects, PC wrap,
// reset over mispredict and a random back-pressure run.
module tb_fetch_unit;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_pc;

  fetch_unit_if if0 ();
  fetch_unit_if if1 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory: data for addr appears the cycle after the request.
  always @(posedge clk) if (if0.imem_req) if0.imem_rdata <= if0.imem_addr ^ XOR_KEY;
  always @(posedge clk) if (if1.imem_req) if1.imem_rdata <= if1.imem_addr ^ XOR_KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stream_cycle(input logic rdy, input logic exp_valid, input string tag);
    @(negedge clk);
    if0.ready_out = rdy;
    #1;
    chk({tag, "_valid"}, 32'(if0.valid_out), 32'(exp_valid));
    if (exp_valid) begin
      chk({tag, "_pc"}, if0.pc_out, exp_pc);
      chk({tag, "_instr"}, if0.instr, exp_pc ^ XOR_KEY);
    end
    if (if0.valid_out && rdy) exp_pc += 32'd4;
  endtask

  task automatic redirect_check(input logic [31:0] target, input string tag);
    @(negedge clk);
    if0.mispredict  = 1'b1;
    if0.redirect_pc = target;
    if0.ready_out   = 1'b1;
    #1;
    chk({tag, "_valid_flush"}, 32'(if0.valid_out), 32'd0);
    chk({tag, "_req_flush"}, 32'(if0.imem_req), 32'd0);
    @(negedge clk);
    if0.mispredict = 1'b0;
    #1;
    chk({tag, "_valid_after"}, 32'(if0.valid_out), 32'd0);
    chk({tag, "_req_after"}, 32'(if0.imem_req), 32'd1);
    chk({tag, "_addr_after"}, if0.imem_addr, {target[31:2], 2'b00});
    exp_pc = {target[31:2], 2'b00};
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_req"}, 32'(if0.imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(if0.valid_out), 32'd0);
    chk({tag, "_instr"}, if0.instr, 32'd0);
    chk({tag, "_pc"}, if0.pc_out, 32'd0);
    chk({tag, "_addr"}, if0.imem_addr, 32'd0);
  endtask

  initial begin
    int   issued;
    int   accepted;
    logic hold_prev;
    logic rdy;

    vectors         = 0;
    miscompares     = 0;
    exp_pc          = 32'h0;
    reset           = 1'b0;
    if0.mispredict  = 1'b0;
    if0.redirect_pc = 32'h0;
    if0.ready_out   = 1'b1;
    if1.mispredict  = 1'b0;
    if1.redirect_pc = 32'h0;
    if1.ready_out   = 1'b1;

    // Reset held
    repeat (3) @(negedge clk);
    #1;
    reset_outputs_zero("rst");

    // Release reset: first request at RESET_PC right away, valid two cycles later
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_req", 32'(if0.imem_req), 32'd1);
    chk("rel_addr", if0.imem_addr, 32'h0);
    exp_pc = 32'h0;
    stream_cycle(1'b1, 1'b0, "rel_gap");
    for (int i = 0; i < 6; i++) begin
      stream_cycle(1'b1, 1'b1, "stream");
      if (i < 4) begin
        chk("wrap_valid", 32'(if1.valid_out), 32'd1);
        chk("wrap_pc", if1.pc_out, 32'hFFFF_FFF8 + 32'(4 * i));
      end
    end

    // Decode stall: buffer fills, requests stop, head held
    for (int i = 0; i < 5; i++) begin
      stream_cycle(1'b0, 1'b1, "stall");
      chk("stall_req", 32'(if0.imem_req), 32'd0);
    end
    for (int i = 0; i < 6; i++) stream_cycle(1'b1, 1'b1, "resume");

    // Redirect with a request in flight; its return must be dropped
    redirect_check(32'h0000_0103, "redir_inflight");
    stream_cycle(1'b1, 1'b0, "redir_inflight_gap");
    for (int i = 0; i < 4; i++) stream_cycle(1'b1, 1'b1, "redir_inflight_stream");

    // Redirect with the buffer full
    for (int i = 0; i < 3; i++) stream_cycle(1'b0, 1'b1, "fill");
    redirect_check(32'h0000_0202, "redir_full");
    stream_cycle(1'b1, 1'b0, "redir_full_gap");
    for (int i = 0; i < 3; i++) stream_cycle(1'b1, 1'b1, "redir_full_stream");

    // Reset together with mispredict: reset wins, restart at RESET_PC
    @(negedge clk);
    reset           = 1'b0;
    if0.mispredict  = 1'b1;
    if0.redirect_pc = 32'h0000_0500;
    #1;
    reset_outputs_zero("rstmp_comb");
    @(negedge clk);
    #1;
    reset_outputs_zero("rstmp_held");
    @(negedge clk);
    reset          = 1'b1;
    if0.mispredict = 1'b0;
    #1;
    chk("restart_req", 32'(if0.imem_req), 32'd1);
    chk("restart_addr", if0.imem_addr, 32'h0);
    exp_pc = 32'h0;
    stream_cycle(1'b1, 1'b0, "restart_gap");
    for (int i = 0; i < 3; i++) stream_cycle(1'b1, 1'b1, "restart_stream");

    // Random back-pressure after a flush so occupancy starts at zero
    @(negedge clk);
    if0.mispredict  = 1'b1;
    if0.redirect_pc = 32'h0000_2000;
    @(negedge clk);
    if0.mispredict = 1'b0;
    #1;
    exp_pc    = 32'h0000_2000;
    issued    = 0;
    accepted  = 0;
    hold_prev = 1'b0;
    if (if0.imem_req) issued++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rdy = 1'($urandom_range(0, 1));
      if0.ready_out = rdy;
      #1;
      if (hold_prev) chk("rand_hold_valid", 32'(if0.valid_out), 32'd1);
      if (if0.valid_out) begin
        chk("rand_pc", if0.pc_out, exp_pc);
        chk("rand_instr", if0.instr, exp_pc ^ XOR_KEY);
      end
      if (if0.imem_req) issued++;
      if (if0.valid_out && rdy) begin
        accepted++;
        exp_pc += 32'd4;
      end
      hold_prev = if0.valid_out && !rdy;
    end
    chk("rand_occupancy_le_depth", 32'((issued - accepted) <= 2 && (issued - accepted) >= 0), 32'd1);
    chk("rand_throughput", 32'(accepted > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
